// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, functs, states
// and the datapath select / ALU class codes (ALUcontrol decodes the same values).
package mc_control_fsm_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_RWB    = 4'd7,
      S_EXEC_I = 4'd8,
      S_IWB    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_JR     = 4'd12
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_RTYPE = 3'b010;
   localparam logic [2:0] ALU_SLTU  = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b100;
   localparam logic [2:0] ALU_LUI   = 3'b101;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_REGA  = 2'b01;
   localparam logic [1:0] SRCA_SHAMT = 2'b10;

   localparam logic [2:0] SRCB_REGB     = 3'b000;
   localparam logic [2:0] SRCB_FOUR     = 3'b001;
   localparam logic [2:0] SRCB_SIMM     = 3'b010;
   localparam logic [2:0] SRCB_SIMM_SH2 = 3'b011;
   localparam logic [2:0] SRCB_ZIMM     = 3'b100;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REGA   = 2'b11;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   // States that hold a memory request open and are therefore timed.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_control_fsm_wait_timer.sv
// Memory-wait cycle counter; expired is high while the count sits at TIMEOUT-1.
module mc_wait_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!resetn)   cnt_q <= '0;
      else if (clr)  cnt_q <= '0;
      else if (en)   cnt_q <= cnt_q + CW'(1);
   end

   assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: one registered state, combinational strobes/selects,
// and a wait timer that aborts stalled memory accesses back to FETCH.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_rdy,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        iord,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_src_a,
   output logic [2:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic [1:0]  reg_dst,
   output logic [1:0]  mem_to_reg,
   output logic        reg_we,
   output logic        bus_err,
   output logic [3:0]  state
);

   state_t     state_q, state_d;
   logic [5:0] opcode, funct;
   logic       expired, tmr_clr, tmr_en;
   logic       unused_instr_bits;

   assign opcode            = instr[31:26];
   assign funct             = instr[5:0];
   assign unused_instr_bits = ^instr[25:6];

   // An abort leaves FETCH->FETCH without a state change, so it must clear the count too.
   assign tmr_en  = is_wait_state(state_q) && !mem_rdy;
   assign tmr_clr = (state_d != state_q) || bus_err;

   mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (expired)
   );

   always_comb begin
      state_d    = state_q;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PCSRC_ALU;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_REGB;
      alu_op     = ALU_ADD;
      reg_dst    = RDST_RT;
      mem_to_reg = M2R_ALUOUT;
      reg_we     = 1'b0;
      bus_err    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_rdy) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               alu_src_b = SRCB_FOUR;
               state_d   = S_DECODE;
            end else if (expired) begin
               mem_rd  = 1'b0;
               bus_err = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_SIMM_SH2;
            case (opcode)
               OP_LW, OP_SW:                       state_d = S_MEMADR;
               OP_RTYPE:                           state_d = (funct == FN_JR) ? S_JR : S_EXEC_R;
               OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: state_d = S_EXEC_I;
               OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
               OP_J, OP_JAL:                       state_d = S_JUMP;
               default:                            state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_SIMM;
            state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            iord   = 1'b1;
            if (mem_rdy) begin
               state_d = S_MEMWB;
            end else if (expired) begin
               mem_rd  = 1'b0;
               bus_err = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEMWB: begin
            mem_to_reg = M2R_MDR;
            reg_we     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_wr = 1'b1;
            iord   = 1'b1;
            if (mem_rdy) begin
               state_d = S_FETCH;
            end else if (expired) begin
               mem_wr  = 1'b0;
               bus_err = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a = (funct == FN_SLL) ? SRCA_SHAMT : SRCA_REGA;
            alu_op    = ALU_RTYPE;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_dst = RDST_RD;
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = SRCA_REGA;
            case (opcode)
               OP_ADDIU: begin alu_src_b = SRCB_SIMM; alu_op = ALU_ADD;  end
               OP_SLTI:  begin alu_src_b = SRCB_SIMM; alu_op = ALU_SLT;  end
               OP_SLTIU: begin alu_src_b = SRCB_SIMM; alu_op = ALU_SLTU; end
               OP_LUI:   begin alu_src_b = SRCB_ZIMM; alu_op = ALU_LUI;  end
               default:  ;
            endcase
            state_d = S_IWB;
         end
         S_IWB: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = SRCA_REGA;
            alu_op    = ALU_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_we     = (opcode == OP_BNE) ? !zero : zero;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src = PCSRC_JUMP;
            pc_we  = 1'b1;
            if (opcode == OP_JAL) begin
               reg_dst    = RDST_RA;
               mem_to_reg = M2R_PC;
               reg_we     = 1'b1;
            end
            state_d = S_FETCH;
         end
         S_JR: begin
            pc_src  = PCSRC_REGA;
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (!resetn) begin
         mem_rd  = 1'b0;
         mem_wr  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         reg_we  = 1'b0;
         bus_err = 1'b0;
         state_d = S_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= S_FETCH;
      else         state_q <= state_d;
   end

   assign state = state_q;

endmodule
